// File: rtl/udp_filter_multi_if.sv
// Stream bundle for udp_filter_multi: the incoming frame beat stream and the
// speculative FIFO write port. Signal names carry the direction as seen from
// the filter (slave side); the master side is the frame source / FIFO owner.
interface udp_filter_multi_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] frame_data_i;
    logic                  frame_data_valid_i;
    logic                  frame_last_i;
    logic                  frame_ready_o;
    logic                  fifo_full_i;
    logic                  fifo_wr_en_o;
    logic [DATA_WIDTH-1:0] fifo_data_o;
    logic                  fifo_last_o;

    modport slave (
        input  frame_data_i, frame_data_valid_i, frame_last_i, fifo_full_i,
        output frame_ready_o, fifo_wr_en_o, fifo_data_o, fifo_last_o
    );

    modport master (
        output frame_data_i, frame_data_valid_i, frame_last_i, fifo_full_i,
        input  frame_ready_o, fifo_wr_en_o, fifo_data_o, fifo_last_o
    );
endinterface

// File: rtl/udp_filter_multi.sv
// udp_filter_multi: streams Ethernet frames into a downstream FIFO
// speculatively and, once the IPv4/UDP header has been seen, either commits
// the frame (frame_valid_o + match_idx_o) or asks the FIFO to rewind it
// (frame_drop_o). Frames arriving with en_i low are consumed silently.
// Optional build macro UDP_FILTER_MULTI_STATS_EN adds saturating
// pass/drop frame counters.
module udp_filter_multi #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_NUM   = 4
) (
    input  logic                        clk_i,
    input  logic                        s_rst_i,
    input  logic                        en_i,
    input  logic [ADDR_NUM*48-1:0]      addr_table_i,
    input  logic [ADDR_NUM-1:0]         entry_en_i,
    udp_filter_multi_if.slave           bus,
    output logic                        frame_valid_o,
    output logic                        frame_drop_o,
    output logic [$clog2(ADDR_NUM)-1:0] match_idx_o
`ifdef UDP_FILTER_MULTI_STATS_EN
    ,
    output logic [31:0]                 pass_cnt_o,
    output logic [31:0]                 drop_cnt_o
`endif
);
    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int HDR_BYTES = 38;               // bytes 0..37 cover every field we inspect
    localparam int IDX_W     = $clog2(ADDR_NUM);
    localparam logic [2:0] VERDICT_BEAT = 3'(37 / BYTES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_PASS = 3'd2;
    localparam logic [2:0] S_DROP = 3'd3;
    localparam logic [2:0] S_SKIP = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [2:0]            beat_q, beat_d;       // beat index within the header, 0 while idle
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;
    logic                  drop_q, drop_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [7:0]            hdr_q [HDR_BYTES];
    logic [7:0]            hdr_v [HDR_BYTES];
    logic                  ready;
    logic                  accept;
    logic                  fixed_ok;
    logic [31:0]           dst_ip;
    logic [15:0]           dst_port;
    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic                  match;

    // Dropped and skipped frames never reach the FIFO, so they ignore back-pressure.
    assign ready  = (state_q == S_DROP || state_q == S_SKIP) ? 1'b1 : !bus.fifo_full_i;
    assign accept = bus.frame_data_valid_i && ready;

    // Capture header bytes as their beat goes by; the verdict beat is read live.
    // NOTE: hdr_q is pure datapath and is only read after being written in the
    // same frame, so it carries no reset and can map onto plain flops/RAM.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < HDR_BYTES; b++) begin
            if (accept && (state_q == S_IDLE || state_q == S_HDR) && beat_q == 3'(b / BYTES))
                hdr_q[b] <= bus.frame_data_i[(b % BYTES)*8 +: 8];
        end
    end

    // Header view at the verdict beat: earlier beats from storage, this beat from the bus.
    always_comb begin
        for (int b = 0; b < HDR_BYTES; b++) begin
            if (3'(b / BYTES) == VERDICT_BEAT) hdr_v[b] = bus.frame_data_i[(b % BYTES)*8 +: 8];
            else                               hdr_v[b] = hdr_q[b];
        end
    end

    assign fixed_ok = hdr_v[12] == 8'h08 && hdr_v[13] == 8'h00 &&
                      hdr_v[14] == 8'h45 && hdr_v[23] == 8'h11;
    assign dst_ip   = {hdr_v[30], hdr_v[31], hdr_v[32], hdr_v[33]};
    assign dst_port = {hdr_v[36], hdr_v[37]};

    // Table lookup: scan downwards so the lowest matching entry is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = ADDR_NUM - 1; k >= 0; k--) begin
            if (entry_en_i[k] && addr_table_i[48*k+16 +: 32] == dst_ip &&
                (addr_table_i[48*k +: 16] == 16'd0 || addr_table_i[48*k +: 16] == dst_port)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end
    assign match = hit && fixed_ok;

    // Next-state and registered-output decode for each accepted beat.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wr_en_d = 1'b0;
        data_d  = data_q;
        last_d  = 1'b0;
        valid_d = 1'b0;
        drop_d  = 1'b0;
        idx_d   = idx_q;
        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (en_i) begin
                        wr_en_d = 1'b1;
                        data_d  = bus.frame_data_i;
                        last_d  = bus.frame_last_i;
                        if (bus.frame_last_i) drop_d = 1'b1;   // single-beat runt
                        else begin
                            state_d = S_HDR;
                            beat_d  = 3'd1;
                        end
                    end else if (!bus.frame_last_i) begin
                        state_d = S_SKIP;
                    end
                end
                S_HDR: begin
                    wr_en_d = 1'b1;
                    data_d  = bus.frame_data_i;
                    last_d  = bus.frame_last_i;
                    if (beat_q == VERDICT_BEAT) begin
                        beat_d = 3'd0;
                        if (match) begin
                            idx_d = hit_idx;
                            if (bus.frame_last_i) begin
                                valid_d = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_PASS;
                            end
                        end else if (bus.frame_last_i) begin
                            drop_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else if (bus.frame_last_i) begin
                        drop_d  = 1'b1;                        // runt: ended before the verdict beat
                        beat_d  = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
                S_PASS: begin
                    wr_en_d = 1'b1;
                    data_d  = bus.frame_data_i;
                    last_d  = bus.frame_last_i;
                    if (bus.frame_last_i) begin
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (bus.frame_last_i) begin
                        drop_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_SKIP: begin
                    if (bus.frame_last_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            state_q <= S_IDLE;
            beat_q  <= 3'd0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.frame_ready_o = ready;
    assign bus.fifo_wr_en_o  = wr_en_q;
    assign bus.fifo_data_o   = data_q;
    assign bus.fifo_last_o   = last_q;
    assign frame_valid_o     = valid_q;
    assign frame_drop_o      = drop_q;
    assign match_idx_o       = idx_q;

`ifdef UDP_FILTER_MULTI_STATS_EN
    logic [31:0] pass_cnt_q, drop_cnt_q;
    logic        skip_done;
    logic [32:0] drop_sum;

    // A disabled frame ends when its last beat is taken in IDLE or SKIP.
    assign skip_done = accept && bus.frame_last_i &&
                       (state_q == S_SKIP || (state_q == S_IDLE && !en_i));
    // A drop pulse and a skipped-frame end can land in the same cycle.
    assign drop_sum  = {1'b0, drop_cnt_q} + 33'(drop_q) + 33'(skip_done);

    // Saturating frame counters.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (valid_q && pass_cnt_q != 32'hFFFF_FFFF) pass_cnt_q <= pass_cnt_q + 32'd1;
            drop_cnt_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
    end

    assign pass_cnt_o = pass_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`endif
endmodule

// File: tb/tb_udp_filter_multi.sv
// Self-checking bench for udp_filter_multi (DATA_WIDTH=64, ADDR_NUM=4):
// directed vector table, reset corner cases and randomized frames checked
// against a byte-level reference model.
module tb_udp_filter_multi;
    localparam int DW    = 64;
    localparam int AN    = 4;
    localparam int BYTES = DW / 8;
    localparam int VBEAT = 37 / BYTES;
    localparam logic [31:0] IP_A = 32'hC0A8_010A;   // 192.168.1.10
    localparam logic [31:0] IP_B = 32'hC0A8_010B;   // 192.168.1.11

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            s_rst_i = 1'b1;
    logic            en_i = 1'b0;
    logic [AN*48-1:0] addr_table = '0;
    logic [AN-1:0]   entry_en = '0;
    logic            frame_valid, frame_drop;
    logic [1:0]      match_idx;

    udp_filter_multi_if #(.DATA_WIDTH(DW)) bus ();

    udp_filter_multi #(.DATA_WIDTH(DW), .ADDR_NUM(AN)) dut (
        .clk_i        (clk),
        .s_rst_i      (s_rst_i),
        .en_i         (en_i),
        .addr_table_i (addr_table),
        .entry_en_i   (entry_en),
        .bus          (bus),
        .frame_valid_o(frame_valid),
        .frame_drop_o (frame_drop),
        .match_idx_o  (match_idx)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- frame and table storage ----------------
    logic [7:0]  fr [128];
    int          fr_len;
    logic [31:0] t_ip   [AN];
    logic [15:0] t_port [AN];
    logic [AN-1:0] t_en;

    function automatic logic [63:0] beat_of(input int j);
        logic [63:0] b;
        for (int i = 0; i < BYTES; i++)
            b[8*i +: 8] = (8*j + i < fr_len) ? fr[8*j + i] : 8'h00;
        return b;
    endfunction

    task automatic build_frame(input int len, input logic [31:0] ip, input logic [15:0] port,
                               input int corrupt);
        fr_len = len;
        for (int i = 0; i < 128; i++) fr[i] = 8'($urandom);
        fr[12] = 8'h08; fr[13] = 8'h00; fr[14] = 8'h45; fr[23] = 8'h11;
        {fr[30], fr[31], fr[32], fr[33]} = ip;
        {fr[36], fr[37]} = port;
        if (corrupt == 1) fr[13] = 8'h06;
        if (corrupt == 2) fr[23] = 8'h06;
        if (corrupt == 3) fr[14] = 8'h46;
    endtask

    task automatic apply_table();
        for (int k = 0; k < AN; k++) addr_table[48*k +: 48] = {t_ip[k], t_port[k]};
        entry_en = t_en;
    endtask

    task automatic set_table_mode(input int mode);
        for (int k = 0; k < AN; k++) begin t_ip[k] = 32'h0; t_port[k] = 16'h0; end
        case (mode)
            1: begin
                t_ip[1] = IP_A; t_port[1] = 16'd0;
                t_ip[2] = IP_A; t_port[2] = 16'd5001;
                t_en = 4'b0110;
            end
            2: begin
                t_ip[0] = IP_A; t_port[0] = 16'd5000;
                t_ip[1] = IP_A; t_port[1] = 16'd5000;
                t_en = 4'b0011;
            end
            default: begin
                t_ip[1] = IP_A; t_port[1] = 16'd5000;
                t_en = 4'b0010;
            end
        endcase
        apply_table();
    endtask

    // Reference model: what the FIFO and pulse outputs should show for the
    // frame in fr[], given its first-beat enable and the current table.
    task automatic model(input bit en, output int e_wr, output int e_valid, output int e_drop,
                         output int e_idx, output bit e_drop_wr);
        int          nb;
        bit          hdr_ok;
        logic [31:0] ip;
        logic [15:0] port;
        nb = (fr_len + BYTES - 1) / BYTES;
        e_wr = 0; e_valid = 0; e_drop = 0; e_idx = 0; e_drop_wr = 1'b0;
        if (!en) return;
        if (nb - 1 < VBEAT) begin             // frame over before the beat holding byte 37
            e_wr = nb; e_drop = 1; e_drop_wr = 1'b1;
            return;
        end
        hdr_ok = fr[12] == 8'h08 && fr[13] == 8'h00 && fr[14] == 8'h45 && fr[23] == 8'h11;
        ip     = {fr[30], fr[31], fr[32], fr[33]};
        port   = {fr[36], fr[37]};
        e_idx  = -1;
        for (int k = 0; k < AN; k++)
            if (e_idx < 0 && hdr_ok && t_en[k] && t_ip[k] == ip &&
                (t_port[k] == 16'd0 || t_port[k] == port)) e_idx = k;
        if (e_idx >= 0) begin
            e_wr = nb; e_valid = 1;
        end else begin
            e_idx = 0; e_wr = VBEAT + 1; e_drop = 1; e_drop_wr = (nb == VBEAT + 1);
        end
    endtask

    // ---------------- output monitor ----------------
    logic [63:0] wq [$];
    logic        lq [$];
    int          m_valid, m_drop, m_both, m_idx;
    bit          m_valid_ok, m_drop_after, m_drop_wr;
    logic        last_acc_q = 1'b0;

    always @(posedge clk)
        last_acc_q <= bus.frame_data_valid_i && bus.frame_ready_o && bus.frame_last_i;

    always @(negedge clk) begin
        if (!s_rst_i) begin
            if (bus.fifo_wr_en_o) begin
                wq.push_back(bus.fifo_data_o);
                lq.push_back(bus.fifo_last_o);
            end
            if (frame_valid) begin
                m_valid++;
                m_idx      = int'(match_idx);
                m_valid_ok = bus.fifo_wr_en_o && bus.fifo_last_o && last_acc_q;
            end
            if (frame_drop) begin
                m_drop++;
                m_drop_after = last_acc_q;
                m_drop_wr    = bus.fifo_wr_en_o && bus.fifo_last_o;
            end
            if (frame_valid && frame_drop) m_both++;
        end
    end

    // ---------------- driver ----------------
    task automatic drive_frame(input bit en, input bit rnd, input int stall_at,
                               input int abort_after, output int stall_low);
        int nb, j, budget, stall_left;
        bit stall_started, acc;
        nb = (fr_len + BYTES - 1) / BYTES;
        j = 0; budget = 0; stall_left = 0; stall_started = 1'b0; stall_low = 0;
        @(posedge clk);
        wq.delete(); lq.delete();
        m_valid = 0; m_drop = 0; m_both = 0; m_idx = 0;
        m_valid_ok = 1'b0; m_drop_after = 1'b0; m_drop_wr = 1'b0;
        while (j < nb && j != abort_after && budget < 1000) begin
            @(negedge clk);
            bus.frame_data_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_at >= 0 && j == stall_at && !stall_started) begin
                stall_started = 1'b1; stall_left = 3;
            end
            if (stall_left > 0) begin
                bus.fifo_full_i = 1'b1; stall_left--;
            end else begin
                bus.fifo_full_i = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            en_i = (j == 0 || !rnd) ? en : 1'($urandom);
            bus.frame_data_i = beat_of(j);
            bus.frame_last_i = (j == nb - 1);
            #1;
            if (bus.fifo_full_i && !bus.frame_ready_o) stall_low++;
            acc = bus.frame_data_valid_i && bus.frame_ready_o;
            @(posedge clk);
            if (acc) j++;
            budget++;
        end
        @(negedge clk);
        bus.frame_data_valid_i = 1'b0;
        bus.frame_last_i = 1'b0;
        bus.fifo_full_i = 1'b0;
        if (budget >= 1000) check("drive_timeout", 64'(budget), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int e_wr, input int e_valid,
                               input int e_drop, input int e_idx, input bit e_drop_wr);
        int nb;
        nb = (fr_len + BYTES - 1) / BYTES;
        check({tag, ".writes"}, 64'(wq.size()), 64'(e_wr));
        for (int i = 0; i < wq.size() && i < e_wr; i++) begin
            check($sformatf("%s.data%0d", tag, i), wq[i], beat_of(i));
            check($sformatf("%s.last%0d", tag, i), 64'(lq[i]), 64'(i == nb - 1));
        end
        check({tag, ".valid_cnt"}, 64'(m_valid), 64'(e_valid));
        check({tag, ".drop_cnt"},  64'(m_drop),  64'(e_drop));
        check({tag, ".both_hi"},   64'(m_both),  64'(0));
        if (e_valid != 0) begin
            check({tag, ".idx"},        64'(m_idx),      64'(e_idx));
            check({tag, ".valid_time"}, 64'(m_valid_ok), 64'(1));
        end
        if (e_drop != 0) begin
            check({tag, ".drop_after_last"}, 64'(m_drop_after), 64'(1));
            check({tag, ".drop_with_write"}, 64'(m_drop_wr),    64'(e_drop_wr));
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int          len;
        logic [31:0] ip;
        logic [15:0] port;
        int          corrupt;
        bit          en;
        int          tmode;
        int          stall_at;
        int          e_wr;
        int          e_valid;
        int          e_drop;
        int          e_idx;
        bit          e_drop_wr;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int stall_low;
        int e_wr, e_valid, e_drop, e_idx;
        bit e_drop_wr, en;
        int len, corrupt;
        logic [31:0] ips [3];
        logic [15:0] ports [3];

        vecs[0]  = '{64, IP_A, 16'd5000, 0, 1'b1, 0, -1, 8, 1, 0, 1, 1'b0};
        vecs[1]  = '{64, IP_A, 16'd5001, 0, 1'b1, 0, -1, 5, 0, 1, 0, 1'b0};
        vecs[2]  = '{64, IP_A, 16'd5001, 0, 1'b1, 1, -1, 8, 1, 0, 1, 1'b0};
        vecs[3]  = '{24, IP_A, 16'd5000, 0, 1'b1, 0, -1, 3, 0, 1, 0, 1'b1};
        vecs[4]  = '{64, IP_A, 16'd5000, 0, 1'b1, 0, -1, 8, 1, 0, 1, 1'b0};
        vecs[5]  = '{64, IP_A, 16'd5000, 0, 1'b1, 0,  5, 8, 1, 0, 1, 1'b0};
        vecs[6]  = '{64, IP_A, 16'd5000, 0, 1'b0, 0, -1, 0, 0, 0, 0, 1'b0};
        vecs[7]  = '{64, IP_B, 16'd5000, 0, 1'b1, 0, -1, 5, 0, 1, 0, 1'b0};
        vecs[8]  = '{64, IP_A, 16'd5000, 2, 1'b1, 0, -1, 5, 0, 1, 0, 1'b0};
        vecs[9]  = '{40, IP_A, 16'd5000, 0, 1'b1, 0, -1, 5, 1, 0, 1, 1'b0};
        vecs[10] = '{40, IP_A, 16'd5001, 0, 1'b1, 0, -1, 5, 0, 1, 0, 1'b1};
        vecs[11] = '{8,  IP_A, 16'd5000, 0, 1'b1, 0, -1, 1, 0, 1, 0, 1'b1};
        vecs[12] = '{8,  IP_A, 16'd5000, 0, 1'b0, 0, -1, 0, 0, 0, 0, 1'b0};
        vecs[13] = '{64, IP_A, 16'd5000, 0, 1'b1, 2, -1, 8, 1, 0, 0, 1'b0};

        bus.frame_data_i = '0;
        bus.frame_data_valid_i = 1'b0;
        bus.frame_last_i = 1'b0;
        bus.fifo_full_i = 1'b0;
        set_table_mode(0);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.wr_en", 64'(bus.fifo_wr_en_o),  64'(0));
        check("rst.last",  64'(bus.fifo_last_o),   64'(0));
        check("rst.data",  bus.fifo_data_o,        64'(0));
        check("rst.valid", 64'(frame_valid),       64'(0));
        check("rst.drop",  64'(frame_drop),        64'(0));
        check("rst.idx",   64'(match_idx),         64'(0));
        check("rst.ready", 64'(bus.frame_ready_o), 64'(1));
        s_rst_i = 1'b0;

        // Directed table.
        for (int v = 0; v < 14; v++) begin
            set_table_mode(vecs[v].tmode);
            build_frame(vecs[v].len, vecs[v].ip, vecs[v].port, vecs[v].corrupt);
            drive_frame(vecs[v].en, 1'b0, vecs[v].stall_at, -1, stall_low);
            check_frame($sformatf("vec%0d", v), vecs[v].e_wr, vecs[v].e_valid,
                        vecs[v].e_drop, vecs[v].e_idx, vecs[v].e_drop_wr);
            if (vecs[v].stall_at >= 0)
                check($sformatf("vec%0d.ready_low", v), 64'(stall_low), 64'(3));
        end

        // Reset in the middle of a passing frame: no pulse, next frame starts clean.
        set_table_mode(0);
        build_frame(64, IP_A, 16'd5000, 0);
        drive_frame(1'b1, 1'b0, -1, 3, stall_low);
        @(negedge clk);
        s_rst_i = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst.wr_en", 64'(bus.fifo_wr_en_o), 64'(0));
        s_rst_i = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst.valid_cnt", 64'(m_valid), 64'(0));
        check("midrst.drop_cnt",  64'(m_drop),  64'(0));
        build_frame(64, IP_A, 16'd5000, 0);
        drive_frame(1'b1, 1'b0, -1, -1, stall_low);
        check_frame("midrst.next", 8, 1, 0, 1, 1'b0);

        // Randomized frames, tables, gaps, back-pressure and mid-frame en_i noise.
        ips   = '{IP_A, IP_B, 32'h0A00_0001};
        ports = '{16'd0, 16'd5000, 16'd5001};
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < AN; k++) begin
                t_ip[k]   = ips[$urandom_range(0, 2)];
                t_port[k] = ports[$urandom_range(0, 2)];
            end
            t_en = 4'($urandom);
            apply_table();
            len     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32))
                                                  : int'($urandom_range(38, 96));
            corrupt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            en      = ($urandom_range(0, 4) != 0);
            build_frame(len, ips[$urandom_range(0, 2)], ports[$urandom_range(1, 2)], corrupt);
            model(en, e_wr, e_valid, e_drop, e_idx, e_drop_wr);
            drive_frame(en, 1'b1, -1, -1, stall_low);
            check_frame($sformatf("rnd%0d", n), e_wr, e_valid, e_drop, e_idx, e_drop_wr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
